// File: rtl/decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per cycle, round keys walked backwards from rk10.
// 20 cycles accept-to-out_valid on a key-cache miss, 10 on a hit; the result holds in DONE until out_ready.
module decrypt_iter #(
  parameter int unsigned KEY_CACHE = 1,
  parameter int unsigned N_K       = 128,
  parameter int unsigned N_B       = 128
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N_K-1:0] k_i,
  input  logic [N_B-1:0] c_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  output logic [N_B-1:0] m_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_ROUND, S_DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gmul(x, x);
      p = gmul(p, x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = rk[31:0]  ^ rk[63:32];
    n2 = rk[63:32] ^ rk[95:64];
    n1 = rk[95:64] ^ rk[127:96];
    n0 = rk[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*col+row) -: 8] = s[127-8*(4*((col-row+4)%4)+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = inv_sub_bytes(inv_shift_rows(s)) ^ rk;
    if (!last) t = {inv_mix_col(t[127:96]), inv_mix_col(t[95:64]),
                    inv_mix_col(t[63:32]), inv_mix_col(t[31:0])};
    return t;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N_K-1:0] rk_q, rk_d;
  logic [N_B-1:0] st_q, st_d;
  logic [N_B-1:0] c_q, c_d;
  logic [N_K-1:0] k_q, k_d;
  logic [N_B-1:0] m_q, m_d;
  logic [N_K-1:0] cache_key_q, cache_key_d;
  logic [N_K-1:0] cache_rk_q, cache_rk_d;
  logic           cache_vld_q, cache_vld_d;

  logic           accept;
  logic           key_hit;
  logic [N_K-1:0] rk_fwd;
  logic [N_K-1:0] rk_inv;
  logic [N_B-1:0] round_out;

  assign accept    = in_valid_i & in_ready_o;
  assign key_hit   = (KEY_CACHE != 0) && cache_vld_q && (k_i == cache_key_q);
  // In EXPAND cnt_q is the forward step index; in ROUND it is r, and rk_q holds rk_{r+1}.
  assign rk_fwd    = key_fwd(rk_q, rcon(cnt_q));
  assign rk_inv    = key_inv(rk_q, rcon(cnt_q + 4'd1));
  assign round_out = inv_round(st_q, rk_inv, cnt_q == 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = key_hit ? S_ROUND : S_EXPAND;
      S_EXPAND: if (cnt_q == 4'd10) state_d = S_ROUND;
      S_ROUND:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:   if (out_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    busy_o      = (state_q == S_EXPAND) || (state_q == S_ROUND);
    out_valid_o = (state_q == S_DONE);
  end

  assign m_o = m_q;

  always_comb begin
    cnt_d       = cnt_q;
    rk_d        = rk_q;
    st_d        = st_q;
    c_d         = c_q;
    k_d         = k_q;
    m_d         = m_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (key_hit) begin
            rk_d  = cache_rk_q;
            st_d  = c_i ^ cache_rk_q;
            cnt_d = 4'd9;
          end else begin
            rk_d  = k_i;
            k_d   = k_i;
            c_d   = c_i;
            cnt_d = 4'd1;
          end
        end
      end
      S_EXPAND: begin
        rk_d  = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          st_d  = c_q ^ rk_fwd;
          cnt_d = 4'd9;
          if (KEY_CACHE != 0) begin
            cache_key_d = k_q;
            cache_rk_d  = rk_fwd;
            cache_vld_d = 1'b1;
          end
        end
      end
      S_ROUND: begin
        rk_d = rk_inv;
        st_d = round_out;
        if (cnt_q == 4'd0) m_d = round_out;
        else               cnt_d = cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      rk_q        <= '0;
      st_q        <= '0;
      c_q         <= '0;
      k_q         <= '0;
      m_q         <= '0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rk_q        <= rk_d;
      st_q        <= st_d;
      c_q         <= c_d;
      k_q         <= k_d;
      m_q         <= m_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
    end
  end

endmodule

// File: tb/tb_decrypt_iter.sv
// Bench for decrypt_iter: FIPS-197 vectors plus random blocks encrypted by a forward AES model.
module tb_decrypt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [127:0] k, c;
  logic         iv1, or1, iv0, or0;
  logic         ir1, ov1, bz1, ir0, ov0, bz0;
  logic [127:0] m1, m0;

  decrypt_iter #(.KEY_CACHE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .k_i(k), .c_i(c), .in_valid_i(iv1), .in_ready_o(ir1),
    .m_o(m1), .out_valid_o(ov1), .out_ready_i(or1), .busy_o(bz1));

  decrypt_iter #(.KEY_CACHE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .k_i(k), .c_i(c), .in_valid_i(iv0), .in_ready_o(ir0),
    .m_o(m0), .out_valid_o(ov0), .out_ready_i(or0), .busy_o(bz0));

  int errors = 0;
  int checks = 0;
  int hs1 = 0;
  int hs0 = 0;

  always @(posedge clk) begin
    if (ov1 && or1) hs1++;
    if (ov0 && or0) hs0++;
  end

  logic [7:0] sbox_t [256];

  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MC1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] MB  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox_t[s[i]];
      for (int cl = 0; cl < 4; cl++)
        for (int r = 0; r < 4; r++) s[r+4*cl] = u[r+4*((cl+r)%4)];
      if (rnd != 10) begin
        for (int cl = 0; cl < 4; cl++) begin
          a0 = s[4*cl]; a1 = s[4*cl+1]; a2 = s[4*cl+2]; a3 = s[4*cl+3];
          s[4*cl]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*cl+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*cl+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*cl+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One request: accept, count cycles to out_valid, optional stall in DONE, then handshake.
  task automatic run_req(input bit sel, input logic [127:0] key, input logic [127:0] ct,
                         input logic [127:0] exp_m, input int exp_lat, input int stall,
                         input string tag);
    int lat, bcnt, ir_bad, hs_start;
    @(negedge clk);
    k = key;
    c = ct;
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    check({tag, ".in_ready_idle"}, 128'(sel ? ir1 : ir0), 128'd1);
    @(posedge clk);
    #1;
    k = rnd128();
    c = rnd128();
    lat = 0; bcnt = 0; ir_bad = 0;
    @(negedge clk);
    while (!(sel ? ov1 : ov0) && lat < 40) begin
      if (sel ? bz1 : bz0) bcnt++;
      if (sel ? ir1 : ir0) ir_bad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    iv1 = 1'b0;
    iv0 = 1'b0;
    check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    check({tag, ".busy_cycles"}, 128'(bcnt), 128'(exp_lat));
    check({tag, ".in_ready_busy"}, 128'(ir_bad), 128'd0);
    check({tag, ".m"}, sel ? m1 : m0, exp_m);
    hs_start = sel ? hs1 : hs0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ".stall_m"}, sel ? m1 : m0, exp_m);
      check({tag, ".stall_vld_rdy"}, 128'({sel ? ov1 : ov0, sel ? ir1 : ir0}), 128'(2'b10));
    end
    if (sel) or1 = 1'b1; else or0 = 1'b1;
    @(posedge clk);
    #1;
    or1 = 1'b0;
    or0 = 1'b0;
    @(negedge clk);
    check({tag, ".post_vld_rdy"}, 128'({sel ? ov1 : ov0, sel ? ir1 : ir0}), 128'(2'b01));
    check({tag, ".post_m_held"}, sel ? m1 : m0, exp_m);
    check({tag, ".handshakes"}, 128'((sel ? hs1 : hs0) - hs_start), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rk, p1, p2;
    rst_n = 1'b1;
    iv1 = 1'b0; or1 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
    k = '0; c = '0;
    build_sbox();
    #1 rst_n = 1'b0;
    #11;
    check("reset.ctrl1", 128'({ir1, ov1, bz1}), 128'(3'b100));
    check("reset.m1", m1, 128'd0);
    check("reset.ctrl0", 128'({ir0, ov0, bz0}), 128'(3'b100));
    check("reset.m0", m0, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, KC1, CC1, MC1, 20, 0, "c1_miss");
    run_req(1'b1, KC1, CC1, MC1, 10, 0, "c1_hit");
    run_req(1'b1, KB,  CB,  MB,  20, 0, "b_miss");
    run_req(1'b1, KC1, CC1, MC1, 20, 0, "c1_after_b");
    run_req(1'b1, KC1, CC1, MC1, 10, 7, "backpressure");

    for (int i = 0; i < 3; i++) begin
      rk = rnd128();
      p1 = rnd128();
      p2 = rnd128();
      run_req(1'b1, rk, aes_enc(rk, p1), p1, 20, 0, "rnd_miss");
      run_req(1'b1, rk, aes_enc(rk, p2), p2, 10, 0, "rnd_hit");
    end

    // Abort a miss at edge 14 (mid-ROUND); its key was cached at edge 10 and must be forgotten.
    rk = rnd128();
    p1 = rnd128();
    @(negedge clk);
    k = rk;
    c = aes_enc(rk, p1);
    iv1 = 1'b1;
    @(posedge clk);
    #1 iv1 = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.ctrl", 128'({ir1, ov1, bz1}), 128'(3'b100));
    check("midrst.m", m1, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(1'b1, rk, aes_enc(rk, p1), p1, 20, 0, "midrst_reissue");

    run_req(1'b0, KC1, CC1, MC1, 20, 0, "nocache_first");
    run_req(1'b0, KC1, CC1, MC1, 20, 0, "nocache_second");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decrypt_iter.md
Name: decrypt_iter

Overview:
Iterative AES-128 decryption engine (FIPS-197 inverse cipher). It takes a cipher key and a ciphertext block over a valid/ready handshake and returns the plaintext block over a second valid/ready handshake. It is the inverse-direction counterpart of the encryption datapath. It computes one round per cycle and derives round keys on the fly in reverse order. An optional last-round-key cache skips key expansion when the key is unchanged.

Parameters:
KEY_CACHE, 1, 1 = retain the expanded last round key (rk10) and its key; a later request with an identical key skips expansion. 0 = always expand.
N_K / N_B, 128 / 128, key and block widths from params.h. Only 128/128 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
k  input  N_K  cipher key; sampled on input accept
c  input  N_B  ciphertext block; sampled on input accept
in_valid  input  1  k/c valid
in_ready  output  1  block can accept a request
m  output  N_B  plaintext block; valid while out_valid=1
out_valid  output  1  m valid
out_ready  input  1  consumer accepts m
busy  output  1  state is EXPAND or ROUND

Behaviour:
- Byte order: FIPS-197 byte 0 at bits [127:120]. Key word w0 = k[127:96].
- Reset (rst=0, async): state IDLE; in_ready=1, out_valid=0, busy=0, m=0; round counter=0; cache invalid. Reset mid-operation abandons the request with no output produced.
- FSM states: IDLE, EXPAND, ROUND, DONE.
- in_ready = (state==IDLE). An input accept is an edge with in_valid & in_ready. k and c are latched on that edge.
- Cache hit condition: KEY_CACHE=1, cache valid, and k equals the cached key. The cached key and rk10 are not modified by a hit.
- On accept with a hit: go to ROUND, st = c ^ rk10_cached, r = 9.
- On accept with a miss: go to EXPAND, rk = k, i = 1.
- EXPAND: one forward key-schedule step per cycle: rk <= next(rk, Rcon[i]), i <= i+1.
- EXPAND exit: on the edge computing rk10, store rk10 and set st = c ^ rk10, r = 9, go to ROUND. If KEY_CACHE=1, also write the cache (key, rk10, valid=1) on this edge.
- ROUND, r = 9 down to 1, per cycle: derive rk_r from rk_{r+1} by the inverse schedule:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[r+1]
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_r)
- ROUND, r = 0: st <= InvSubBytes(InvShiftRows(st)) ^ rk0 (no InvMixColumns), with rk0 derived the same way. Go to DONE with m = result, out_valid = 1.
- Latency, counting the accept edge as edge 0: out_valid rises after edge 20 on a miss, after edge 10 on a hit.
- DONE: m and out_valid hold stable while out_ready=0. On the edge with out_ready=1, go to IDLE and clear out_valid. m is held, not cleared. The next input can be accepted one cycle after the output handshake.
- in_valid while busy is ignored (in_ready=0). k/c may change after accept without effect.
- The S-box and inverse S-box come from the team's shared round-function primitives. The block holds only the state, round-key and cache registers and the FSM.

Test Plan:
- FIPS-197 App. C.1: k=000102030405060708090a0b0c0d0e0f, c=69c4e0d86a7b0430d8cdb78070b4c55a -> m=00112233445566778899aabbccddeeff; out_valid after edge 20; in_ready=0 throughout.
- Cache hit, KEY_CACHE=1: repeat the C.1 request -> same m, out_valid after edge 10; busy high for exactly 10 cycles.
- Key change: App. B, k=2b7e151628aed2a6abf7158809cf4f3c, c=3925841d02dc09fbdc118597196a0b32 -> m=3243f6a8885a308d313198a2e0370734 after 20 cycles; then a C.1 request takes 20 cycles (miss).
- Backpressure: hold out_ready=0 for 7 cycles in DONE -> m stable and out_valid=1; in_ready=0; single output handshake on release; in_ready=1 the next cycle.
- Reset mid-ROUND: assert rst=0 at edge 14 of a miss request -> out_valid=0, in_ready=1, m=0 immediately (asynchronously). Re-issuing the same key afterwards is a miss (20 cycles).
- KEY_CACHE=0 build: back-to-back identical keys -> both requests take 20 cycles.
